icache_refill: RTL and testbench
================================

# icache_refill

Miss-refill engine feeding the instruction cache. On an instruction-cache miss it latches the block-aligned address and obtains the byte-wide memory port from the memory arbiter. It then streams one cache block plus two trailing bytes into a shift buffer and issues a single-cycle write into the cache's data array. The block sits between the instruction-fetch miss signal and the memory arbiter, and produces the cache's `we` and `block` inputs.

## Interface
- `OFFSET_BIT`, default 4: log2 of block bytes; `BLOCK_BYTES = 2**OFFSET_BIT` = 16.
- `FETCH_BYTES`, derived: `BLOCK_BYTES + 2` = 18. The 2 extra bytes cover a 32-bit instruction straddling the block end.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  global pause; when low, all state, counters and outputs hold.
- `flush`  in  1  pipeline clear (branch mispredict); aborts an in-progress refill.
- `miss_valid`  in  1  fetch stage reports a miss at `miss_addr`; held until `busy` returns low.
- `miss_addr`  in  32  missing instruction address.
- `busy`  out  1  high in every state except IDLE.
- `mem_req`  out  1  request for the byte memory port.
- `mem_gnt`  in  1  arbiter grant; once asserted it stays high until `mem_req` drops.
- `mem_addr`  out  32  byte address issued this cycle.
- `mem_din`  in  8  byte returned for the address issued in the previous cycle.
- `cache_we`  out  1  one-cycle write strobe to the cache.
- `refill_addr`  out  32  block base address, valid while `cache_we` is high (drives the cache's tag/index).
- `block`  out  `8*FETCH_BYTES` (144)  fetched bytes. Byte j sits at bits [8j+7:8j] and is the byte at `refill_addr + j`.

## Operation
- States: IDLE, WAIT_GNT, FETCH, DONE.
- IDLE → WAIT_GNT when `miss_valid && !flush`.
  - Latch `base = miss_addr` with bits [OFFSET_BIT-1:0] cleared.
  - Clear `issue_cnt` and `recv_cnt`.
- WAIT_GNT: `mem_req` = 1. When `mem_gnt` is sampled high, go to FETCH.
- FETCH:
  - `mem_req` = 1.
  - While `issue_cnt < FETCH_BYTES`: drive `mem_addr = base + issue_cnt`, then increment `issue_cnt`.
  - Each cycle after an issue, capture `mem_din` into byte `recv_cnt` of the buffer, then increment `recv_cnt`.
  - When byte `FETCH_BYTES-1` is captured, go to DONE.
- DONE:
  - `cache_we` = 1, `refill_addr = base`, `block` = buffer, `mem_req` = 0.
  - Next state IDLE.
  - Completes even if `flush` is high, because the fetched bytes are valid memory contents.
- Address arithmetic is a plain 32-bit add with no block wrap. Bytes 16–17 come from the next block (`base+16`, `base+17`).
- `mem_addr` outside FETCH-issue cycles: 0. `block` and `refill_addr` hold their last values outside DONE.
- `flush` in WAIT_GNT or FETCH: next state IDLE, `mem_req` low the next cycle, no `cache_we`. Any byte still in flight is discarded.
- `flush` and `miss_valid` high together in IDLE: no start.
- Reset (any state): next state IDLE. All outputs 0; buffer, `base` and counters 0.
- `rdy_in` low: full hold, including counters mid-FETCH. The arbiter and memory also obey `rdy_in`, so the in-flight byte is presented again when `rdy_in` returns high.

## Timing
- Edge E0 samples `miss_valid`; WAIT_GNT is entered at E0.
- With `mem_gnt` already high, the grant is sampled at E1 and FETCH starts.
- FETCH lasts `FETCH_BYTES+1` = 19 cycles: 18 issue cycles, with the last capture on the 19th.
- DONE (`cache_we` high) is one cycle. Back in IDLE one cycle later.
- Miss-to-`cache_we` = 21 cycles when the grant is immediate. Each cycle of grant delay adds one.
- `busy` falls in the cycle after DONE. A new miss can be accepted in that same cycle.

## Test plan
- Reset with `rst_in` high for 3 cycles, `miss_valid` high → `busy`, `mem_req`, `cache_we` stay 0; state IDLE.
- Miss at `0x00001236`, memory byte = address[7:0], immediate grant → `mem_addr` runs 0x1230..0x1241. `cache_we` pulses once at cycle 21 with `refill_addr = 0x1230`, `block[7:0] = 0x30`, `block[143:136] = 0x41`.
- Grant delayed 5 cycles → `mem_req` high throughout, no `mem_addr` issue before the grant, `cache_we` at cycle 26.
- `flush` at FETCH cycle 7 → `mem_req` low next cycle, no `cache_we`. A following miss at `0x40` refills correctly, with no stale bytes from the aborted refill.
- `rdy_in` low for 4 cycles mid-FETCH (after byte 9) → counters and `mem_addr` hold; the final block is identical to the run without the pause.
- `flush` during DONE → `cache_we` still pulses once; back-to-back misses at `0x1FFF0` then `0x0` are both written, the first with `block[143:128]` from `0x20000`/`0x20001`.

Source files
------------

// File: rtl/icache_refill_if.sv
// rtl/icache_refill_if.sv - miss, memory-port and cache-write signals of the icache refill engine
interface icache_refill_if #(
  parameter int OFFSET_BIT = 4
);
  localparam int FETCH_BYTES = (2 ** OFFSET_BIT) + 2;

  logic                     miss_valid;
  logic [31:0]              miss_addr;
  logic                     busy;
  logic                     mem_req;
  logic                     mem_gnt;
  logic [31:0]              mem_addr;
  logic [7:0]               mem_din;
  logic                     cache_we;
  logic [31:0]              refill_addr;
  logic [8*FETCH_BYTES-1:0] block;

  modport master (
    input  miss_valid,
    input  miss_addr,
    input  mem_gnt,
    input  mem_din,
    output busy,
    output mem_req,
    output mem_addr,
    output cache_we,
    output refill_addr,
    output block
  );

  modport slave (
    output miss_valid,
    output miss_addr,
    output mem_gnt,
    output mem_din,
    input  busy,
    input  mem_req,
    input  mem_addr,
    input  cache_we,
    input  refill_addr,
    input  block
  );
endinterface

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache miss refill: fetches one block plus two trailing bytes, then one cache write
module icache_refill #(
  parameter int OFFSET_BIT = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            flush,
  icache_refill_if.master bus
);
  localparam int BLOCK_BYTES = 2 ** OFFSET_BIT;
  localparam int FETCH_BYTES = BLOCK_BYTES + 2;
  localparam int CNT_W       = $clog2(FETCH_BYTES + 1);
  localparam int BLK_W       = 8 * FETCH_BYTES;

  localparam logic [CNT_W-1:0] FETCH_CNT = CNT_W'(FETCH_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FETCH_BYTES - 1);
  localparam logic [31:0]      BASE_MASK = ~((32'd1 << OFFSET_BIT) - 32'd1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_GNT = 2'd1;
  localparam logic [1:0] S_FETCH    = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]       state;
  logic [31:0]      base;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic [BLK_W-1:0] buf_q;
  logic [BLK_W-1:0] buf_next;
  logic [BLK_W-1:0] block_q;
  logic [31:0]      refill_addr_q;
  logic             issuing;
  logic             capturing;

  // Memory answers one cycle after the issue, so receive trails issue by at most one byte.
  assign issuing   = (state == S_FETCH) && (issue_cnt < FETCH_CNT);
  assign capturing = (state == S_FETCH) && (recv_cnt != issue_cnt);

  always_comb begin
    buf_next = buf_q;
    for (int j = 0; j < FETCH_BYTES; j++) begin
      if (recv_cnt == CNT_W'(j)) begin
        buf_next[8*j +: 8] = bus.mem_din;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      base          <= '0;
      issue_cnt     <= '0;
      recv_cnt      <= '0;
      buf_q         <= '0;
      block_q       <= '0;
      refill_addr_q <= '0;
    end else if (rdy_in) begin
      case (state)
        S_IDLE: begin
          if (bus.miss_valid && !flush) begin
            state     <= S_WAIT_GNT;
            base      <= bus.miss_addr & BASE_MASK;
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end
        end
        S_WAIT_GNT: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (bus.mem_gnt) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (issuing) begin
              issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (capturing) begin
              buf_q    <= buf_next;
              recv_cnt <= recv_cnt + CNT_W'(1);
              // Publish on the last capture so block/refill_addr are stable for the whole DONE cycle.
              if (recv_cnt == LAST_IDX) begin
                state         <= S_DONE;
                block_q       <= buf_next;
                refill_addr_q <= base;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.mem_req     = (state == S_WAIT_GNT) || (state == S_FETCH);
  assign bus.cache_we    = (state == S_DONE);
  assign bus.mem_addr    = issuing ? (base + {{(32-CNT_W){1'b0}}, issue_cnt}) : 32'd0;
  assign bus.refill_addr = refill_addr_q;
  assign bus.block       = block_q;
endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - table-driven and randomized checks of icache_refill against a block-level model
`timescale 1ns/1ps
module tb_icache_refill;
  localparam int OFFSET_BIT  = 4;
  localparam int FETCH_BYTES = (2 ** OFFSET_BIT) + 2;
  localparam int BLK_W       = 8 * FETCH_BYTES;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush;

  int checks    = 0;
  int failures  = 0;
  int gnt_delay = 0;
  int req_cnt   = 0;
  int mem_mode  = 0;
  logic [7:0] mem_din_r = 8'h00;

  logic [BLK_W-1:0] last_block;
  logic [31:0]      last_refill;
  int               last_lat;
  int               last_we;

  typedef struct {
    logic [31:0] addr;
    int          gd;
    int          pause_at;
    int          pause_len;
    int          flush_at;
    int          mode;
    logic [31:0] exp_base;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vecs[7];

  icache_refill_if #(.OFFSET_BIT(OFFSET_BIT)) bus ();

  icache_refill #(.OFFSET_BIT(OFFSET_BIT)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] mem_fn(input logic [31:0] a, input int mode);
    if (mode == 0) return a[7:0];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5a;
  endfunction

  function automatic logic [BLK_W-1:0] model_block(input logic [31:0] base, input int mode);
    logic [BLK_W-1:0] b;
    b = '0;
    for (int j = 0; j < FETCH_BYTES; j++) b[8*j +: 8] = mem_fn(base + 32'(j), mode);
    return b;
  endfunction

  // Byte memory: returns the byte for last cycle's address, frozen while rdy_in is low.
  always @(posedge clk_in) begin
    if (rdy_in === 1'b1) mem_din_r <= mem_fn(bus.mem_addr, mem_mode);
  end

  // Arbiter: grants after gnt_delay requesting cycles, holds the grant until mem_req drops.
  always @(posedge clk_in) begin
    if (rst_in === 1'b1 || bus.mem_req !== 1'b1) req_cnt <= 0;
    else if (rdy_in === 1'b1 && req_cnt < 1000) req_cnt <= req_cnt + 1;
  end

  assign bus.mem_din = mem_din_r;
  assign bus.mem_gnt = (bus.mem_req === 1'b1) && (req_cnt >= gnt_delay);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.miss_valid = 1'b0;
    flush = 1'b0;
    rdy_in = 1'b1;
    repeat (n) begin
      @(posedge clk_in); #1;
      check("idle_busy", bus.busy, 1'b0);
    end
  endtask

  // One miss from the current cycle (eff 0) to the first IDLE cycle after it; eff counts rdy-qualified edges.
  task automatic run_miss(input logic [31:0] addr, input int gd, input int pause_at, input int pause_len,
                          input int flush_at, input int mode);
    logic [31:0] base;
    logic [31:0] exp_addr;
    logic        exp_busy, exp_req, exp_we;
    int          eff, wall, pause_left, end_eff;
    bit          paused, abort;
    base       = addr & ~((32'd1 << OFFSET_BIT) - 32'd1);
    gnt_delay  = gd;
    mem_mode   = mode;
    abort      = (flush_at >= 1) && (flush_at <= 20 + gd);
    end_eff    = abort ? flush_at + 1 : 22 + gd;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = addr;
    flush = 1'b0;
    rdy_in = 1'b1;
    eff = 0; wall = 0; pause_left = 0; paused = 0;
    last_lat = -1; last_we = 0;
    while (eff < end_eff && wall < 200) begin
      @(posedge clk_in); #1;
      wall++;
      if (rdy_in) eff++;
      if (abort && eff > flush_at) begin
        exp_busy = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'd0;
      end else begin
        exp_busy = (eff >= 1) && (eff <= 21 + gd);
        exp_req  = (eff >= 1) && (eff <= 20 + gd);
        exp_we   = (eff == 21 + gd);
        exp_addr = (eff >= 2 + gd && eff <= 19 + gd) ? base + 32'(eff - 2 - gd) : 32'd0;
      end
      check("busy", bus.busy, exp_busy);
      check("mem_req", bus.mem_req, exp_req);
      check("cache_we", bus.cache_we, exp_we);
      check("mem_addr", bus.mem_addr, exp_addr);
      if (bus.cache_we === 1'b1) begin
        last_we++;
        if (last_lat < 0) last_lat = wall;
        last_block  = bus.block;
        last_refill = bus.refill_addr;
      end
      flush = (eff == flush_at);
      if (eff >= 21 + gd || (abort && eff >= flush_at)) bus.miss_valid = 1'b0;
      if (pause_left > 0) begin
        rdy_in = 1'b0;
        pause_left--;
      end else if (!paused && pause_len > 0 && eff == pause_at) begin
        paused = 1;
        rdy_in = 1'b0;
        pause_left = pause_len - 1;
      end else begin
        rdy_in = 1'b1;
      end
    end
    check("cycle_budget", eff == end_eff, 1'b1);
    flush = 1'b0;
    rdy_in = 1'b1;
  endtask

  task automatic check_result(input logic [31:0] addr, input int mode, input logic [31:0] exp_base,
                              input int exp_lat, input int exp_we);
    check("we_count", last_we, exp_we);
    check("latency", last_lat, exp_lat);
    if (exp_we != 0) begin
      check("refill_addr", last_refill, exp_base);
      check_blk("block", last_block, model_block(addr & ~((32'd1 << OFFSET_BIT) - 32'd1), mode));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    int gd, pl, pa, fa, ew, el;

    vecs[0] = '{32'h0000_1236, 0, -1, 0, -1, 0, 32'h0000_1230, 21, 1};
    vecs[1] = '{32'h0000_1236, 5, -1, 0, -1, 0, 32'h0000_1230, 26, 1};
    vecs[2] = '{32'h0000_5555, 0, -1, 0,  8, 1, 32'h0000_5550, -1, 0};
    vecs[3] = '{32'h0000_0040, 0, -1, 0, -1, 1, 32'h0000_0040, 21, 1};
    vecs[4] = '{32'h0000_1236, 0, 13, 4, -1, 0, 32'h0000_1230, 25, 1};
    vecs[5] = '{32'hFFFF_FFFE, 2, -1, 0, -1, 1, 32'hFFFF_FFF0, 23, 1};
    vecs[6] = '{32'h8765_4321, 1, -1, 0,  2, 1, 32'h8765_4320, -1, 0};

    // Reset held 3 cycles with a pending miss: nothing may start.
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    bus.miss_valid = 1'b1; bus.miss_addr = 32'h0000_1236;
    repeat (3) begin
      @(posedge clk_in); #1;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_cache_we", bus.cache_we, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_refill_addr", bus.refill_addr, 32'd0);
      check_blk("rst_block", bus.block, '0);
    end
    bus.miss_valid = 1'b0;
    rst_in = 1'b0;
    idle(2);

    // flush together with miss in IDLE: no start.
    bus.miss_valid = 1'b1; bus.miss_addr = 32'h0000_2000; flush = 1'b1;
    @(posedge clk_in); #1;
    check("flush_miss_busy", bus.busy, 1'b0);
    check("flush_miss_req", bus.mem_req, 1'b0);
    idle(2);

    for (int i = 0; i < 7; i++) begin
      run_miss(vecs[i].addr, vecs[i].gd, vecs[i].pause_at, vecs[i].pause_len, vecs[i].flush_at, vecs[i].mode);
      check_result(vecs[i].addr, vecs[i].mode, vecs[i].exp_base, vecs[i].exp_lat, vecs[i].exp_we);
      if (i == 0) begin
        check("byte0", {24'd0, last_block[7:0]}, 32'h30);
        check("byte17", {24'd0, last_block[143:136]}, 32'h41);
      end
      idle(2);
    end

    // flush in DONE still writes; next miss is accepted in the cycle busy falls.
    run_miss(32'h0001_FFF0, 0, -1, 0, 21, 1);
    check_result(32'h0001_FFF0, 1, 32'h0001_FFF0, 21, 1);
    check("next_block_bytes", {16'd0, last_block[143:128]},
          {16'd0, mem_fn(32'h0002_0001, 1), mem_fn(32'h0002_0000, 1)});
    run_miss(32'h0000_0000, 0, -1, 0, -1, 1);
    check_result(32'h0000_0000, 1, 32'h0000_0000, 21, 1);
    idle(1);

    for (int n = 0; n < 20; n++) begin
      ra = $urandom;
      gd = $urandom_range(0, 4);
      pl = 0; pa = -1; fa = -1;
      if ($urandom_range(0, 3) == 0) begin
        fa = $urandom_range(1, 20 + gd);
      end else begin
        pl = $urandom_range(0, 3);
        pa = $urandom_range(1, 20 + gd);
      end
      ew = (fa >= 0) ? 0 : 1;
      el = (fa >= 0) ? -1 : 21 + gd + pl;
      run_miss(ra, gd, pa, pl, fa, 1);
      check_result(ra, 1, ra & ~((32'd1 << OFFSET_BIT) - 32'd1), el, ew);
      idle($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
